// File: rtl/elastic_pipe.sv
// Elastic FIFO buffer with valid/ready handshake on both sides.
// Registered head output, explicit pointer wrap, synchronous flush.
module elastic_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             push, pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready comes from registered count only; rst_n keeps it low in reset.
    assign in_ready  = rst_n & (cnt_q != CW'(DEPTH)) & ~flush;
    assign out_valid = (cnt_q != '0) & ~flush;
    assign out_data  = dout_q;
    assign count     = cnt_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = inc(wr_q);
            if (pop)  rd_d = inc(rd_q);
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
            // New head is the incoming word when the buffer was empty after pop.
            if (cnt_d != '0) begin
                if (push && cnt_d == CW'(1))
                    dout_d = in_data;
                else
                    dout_d = mem[rd_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= in_data;
    end

    a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q <= CW'(DEPTH));

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && cnt_q == CW'(DEPTH)));

    a_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=>
            (flush || (out_valid && $stable(out_data))));

endmodule

// File: doc/elastic_pipe.md
Name: elastic_pipe

Overview:
- Parametrised elastic buffer with a valid/ready handshake on both sides. It replaces the single-entry pipeline register wherever a stage needs more than one entry of slack.
- Sustains one transfer per cycle at DEPTH >= 2.
- Decouples in_ready from out_ready, so there is no combinational ready path through the block.
- Sits between producer and consumer stages of the datapath and exposes an occupancy count and a synchronous flush.

Parameters:
- WIDTH, 32, payload width in bits (>= 1).
- DEPTH, 4, number of storage entries (>= 2; need not be a power of two).
- CW, $clog2(DEPTH+1), width of count output (derived, not overridden).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all contents.
- in_valid  input  1  producer has data.
- in_ready  output  1  block can accept data this cycle.
- in_data  input  WIDTH  producer payload.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head this cycle.
- out_data  output  WIDTH  head payload.
- count  output  CW  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - write pointer, read pointer and count go to 0.
  - out_valid=0, out_data=0, in_ready=0 while rst_n=0.
  - in_ready=1 from the first cycle after release.
  - Storage contents need not be reset; out_data must still read 0 until the first write.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Data transfers only on the clock edge where the handshake is true.
- Ready and valid generation:
  - in_ready = (count != DEPTH) & !flush, decoded from registered count only. It never depends on out_ready or in_valid.
  - out_valid = (count != 0) & !flush.
- Latency: a word pushed at edge N is presented on out_data with out_valid=1 after edge N (first-word-fall-through of a registered entry; 1-cycle latency). There is no combinational in_data-to-out_data path.
- Ordering: strict FIFO, no loss, no duplication.
- Push and pop in the same cycle: count unchanged and both pointers advance. With DEPTH >= 2 this gives full throughput indefinitely.
- Full (count=DEPTH):
  - in_ready=0, even if pop occurs that cycle.
  - in_ready returns to 1 the cycle after the pop edge.
- Empty (count=0):
  - out_valid=0.
  - out_ready is ignored.
  - out_data is held at its last value.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid must not change, regardless of push activity.
- Pointer wrap: pointers count 0..DEPTH-1 and wrap to 0 explicitly, which makes non-power-of-2 DEPTH legal.
- Count arithmetic:
  - push & !pop: +1.
  - pop & !push: -1.
  - Must never exceed DEPTH or underflow.
- Flush (synchronous):
  - On an edge with flush=1, pointers and count go to 0.
  - Since in_ready and out_valid are forced 0 during the flush cycle, no push or pop occurs that cycle.
  - Entries present before the flush are never output.
  - flush has priority over all other activity.
- Reset mid-operation: asynchronous assertion discards all contents immediately; the block behaves exactly as after power-on reset.
- Assertions required in RTL:
  - count <= DEPTH.
  - no push when count=DEPTH.
  - out_data stable under backpressure.

Test Plan:
- Reset, DEPTH=4: rst_n low 5 cycles, release -> out_valid=0, count=0, out_data=0, and in_ready=1 on the first cycle after release.
- Streaming, out_ready=1: push 10..14 on consecutive cycles -> out_data sequence 10..14, each appearing 1 cycle after its push; in_ready stays 1; count stays <=1.
- Backpressure fill, out_ready=0: push 0xDEADBEEF then 1, 2, 3 -> count=4 and in_ready=0 after the 4th edge. A 5th value held on in_data is not accepted. Raising out_ready drains 0xDEADBEEF, 1, 2, 3 in order, and in_ready=1 the cycle after the first pop.
- Full with simultaneous events: at count=4 with in_valid=1 and out_ready=1 -> no push that cycle and count=3 after the edge. With continuous traffic the next cycle, count holds at 3.
- Flush and wrap, DEPTH=3: fill with A, B, C, pop A, push D (write pointer wraps to 0), assert flush one cycle -> count=0 and out_valid=0; then push E -> E is the next output, and B, C, D are never output.
- Random soak: 1000 cycles of random in_valid/out_ready with a scoreboard, plus rst_n asserted mid-run -> output matches the reference queue in order, the queue is emptied on reset, and no assertion fires.
